// File: rtl/trap_pkg.sv
// Shared trap sequencer definitions: FSM states, CSR numbers,
// mstatus bit positions and the mstatus entry/exit updates.
package trap_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE       = 3'd0;
  localparam state_t S_W_MEPC     = 3'd1;
  localparam state_t S_W_MCAUSE   = 3'd2;
  localparam state_t S_W_MSTATUS  = 3'd3;
  localparam state_t S_MRET_MSTAT = 3'd4;
  localparam state_t S_JUMP       = 3'd5;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int          TRAP_MIE_BIT    = 3;
  localparam int          TRAP_MPIE_BIT   = 7;
  localparam logic [31:0] TRAP_MTVEC_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] mstatus_enter(
    input logic [31:0] ms,
    input int          mie,
    input int          mpie
  );
    logic [31:0] r;
    r       = ms;
    r[mpie] = ms[mie];
    r[mie]  = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_exit(
    input logic [31:0] ms,
    input int          mie,
    input int          mpie
  );
    logic [31:0] r;
    r       = ms;
    r[mie]  = ms[mpie];
    r[mpie] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Trap sequencer: owns the clint-side CSR write port, performs
// trap entry (mepc, mcause, mstatus) and mret, then redirects fetch.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_ALIGN_MASK = TRAP_MTVEC_MASK,
  parameter int          INT_MIE_BIT      = TRAP_MIE_BIT,
  parameter int          INT_MPIE_BIT     = TRAP_MPIE_BIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic        int_req_i,
  input  logic [31:0] int_cause_i,
  input  logic [31:0] int_pc_i,
  input  logic        mret_i,
  input  logic        exu_csr_we_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        hold_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o
);

  state_t      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] target_q, target_d;

  logic take_int;
  assign take_int = int_req_i & mstatus_i[INT_MIE_BIT];

  always_comb begin
    state_d     = state_q;
    epc_d       = epc_q;
    cause_d     = cause_q;
    target_d    = target_q;
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    hold_o      = 1'b0;
    jump_o      = 1'b0;
    jump_addr_o = '0;
    unique case (state_q)
      S_IDLE: begin
        // accept-cycle hold is combinational; masked while in reset
        if (exc_req_i) begin
          epc_d   = exc_pc_i;
          cause_d = exc_cause_i;
          state_d = S_W_MEPC;
          hold_o  = ~rst;
        end else if (mret_i) begin
          state_d = S_MRET_MSTAT;
          hold_o  = ~rst;
        end else if (take_int) begin
          epc_d   = int_pc_i;
          cause_d = int_cause_i;
          state_d = S_W_MEPC;
          hold_o  = ~rst;
        end
      end
      S_W_MEPC: begin
        hold_o      = 1'b1;
        csr_we_o    = ~exu_csr_we_i;
        csr_waddr_o = {20'd0, CSR_MEPC};
        csr_wdata_o = epc_q;
        if (!exu_csr_we_i) state_d = S_W_MCAUSE;
      end
      S_W_MCAUSE: begin
        hold_o      = 1'b1;
        csr_we_o    = ~exu_csr_we_i;
        csr_waddr_o = {20'd0, CSR_MCAUSE};
        csr_wdata_o = cause_q;
        if (!exu_csr_we_i) state_d = S_W_MSTATUS;
      end
      S_W_MSTATUS: begin
        hold_o      = 1'b1;
        csr_we_o    = ~exu_csr_we_i;
        csr_waddr_o = {20'd0, CSR_MSTATUS};
        csr_wdata_o = mstatus_enter(mstatus_i, INT_MIE_BIT,
                                    INT_MPIE_BIT);
        if (!exu_csr_we_i) begin
          target_d = mtvec_i & MTVEC_ALIGN_MASK;
          state_d  = S_JUMP;
        end
      end
      S_MRET_MSTAT: begin
        hold_o      = 1'b1;
        csr_we_o    = ~exu_csr_we_i;
        csr_waddr_o = {20'd0, CSR_MSTATUS};
        csr_wdata_o = mstatus_exit(mstatus_i, INT_MIE_BIT,
                                   INT_MPIE_BIT);
        if (!exu_csr_we_i) begin
          target_d = mepc_i;
          state_d  = S_JUMP;
        end
      end
      S_JUMP: begin
        hold_o      = 1'b1;
        jump_o      = 1'b1;
        jump_addr_o = target_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl with a behavioural csr_reg
// model, directed vector table, hand sequences and random traffic.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req_i, int_req_i, mret_i, exu_csr_we_i;
  logic [31:0] exc_cause_i, exc_pc_i, int_cause_i, int_pc_i;
  logic [31:0] mtvec_i, mepc_i, mstatus_i;
  logic        csr_we_o, hold_o, jump_o;
  logic [31:0] csr_waddr_o, csr_wdata_o, jump_addr_o;

  int checks = 0;
  int errors = 0;

  // behavioural csr_reg contents seen by the DUT
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
  assign mstatus_i = m_mstatus;
  assign mtvec_i   = m_mtvec;
  assign mepc_i    = m_mepc;

  logic        s_we;
  logic [31:0] s_a, s_d;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk(clk), .rst(rst),
    .exc_req_i(exc_req_i), .exc_cause_i(exc_cause_i),
    .exc_pc_i(exc_pc_i), .int_req_i(int_req_i),
    .int_cause_i(int_cause_i), .int_pc_i(int_pc_i),
    .mret_i(mret_i), .exu_csr_we_i(exu_csr_we_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mstatus_i(mstatus_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
    .csr_wdata_o(csr_wdata_o), .hold_o(hold_o),
    .jump_o(jump_o), .jump_addr_o(jump_addr_o)
  );

  typedef struct {
    string       name;
    bit          exc, mret, intr;
    logic [31:0] ecause, epc, icause, ipc;
    logic [31:0] ms, mtvec, mepc;
    int          sat, slen;
    logic [31:0] e_mepc, e_mcause, e_ms, e_jaddr;
    int          e_jc, e_nwe;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic csr_write(input logic [31:0] a, input logic [31:0] d);
    case (a)
      32'h341: m_mepc    = d;
      32'h342: m_mcause  = d;
      32'h300: m_mstatus = d;
      default: ;
    endcase
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
    if (s_we) csr_write(s_a, s_d);
    s_we = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
    s_we = csr_we_o;
    s_a  = csr_waddr_o;
    s_d  = csr_wdata_o;
  endtask

  task automatic idle_inputs();
    exc_req_i = 0; mret_i = 0; int_req_i = 0; exu_csr_we_i = 0;
  endtask

  function automatic vec_t mkv(
    string nm, bit e, bit m, bit i,
    logic [31:0] ec, logic [31:0] ep, logic [31:0] ic, logic [31:0] ip,
    logic [31:0] ms, logic [31:0] tv, logic [31:0] mp,
    int sat, int slen,
    logic [31:0] x_mepc, logic [31:0] x_mcause, logic [31:0] x_ms,
    int x_jc, logic [31:0] x_ja, int x_nwe);
    vec_t v;
    v.name = nm; v.exc = e; v.mret = m; v.intr = i;
    v.ecause = ec; v.epc = ep; v.icause = ic; v.ipc = ip;
    v.ms = ms; v.mtvec = tv; v.mepc = mp; v.sat = sat; v.slen = slen;
    v.e_mepc = x_mepc; v.e_mcause = x_mcause; v.e_ms = x_ms;
    v.e_jc = x_jc; v.e_jaddr = x_ja; v.e_nwe = x_nwe;
    return v;
  endfunction

  // reference: trap entry/mret effects from the architectural rules
  function automatic vec_t predict(vec_t v);
    vec_t r = v;
    bit   mie  = v.ms[3];
    bit   mpie = v.ms[7];
    r.e_mepc = v.mepc; r.e_mcause = 0; r.e_ms = v.ms;
    r.e_jc = -1; r.e_jaddr = 0; r.e_nwe = 0;
    if (v.exc || (!v.mret && v.intr && mie)) begin
      r.e_mepc   = v.exc ? v.epc : v.ipc;
      r.e_mcause = v.exc ? v.ecause : v.icause;
      r.e_ms     = (v.ms & 32'hFFFF_FF77) | (mie ? 32'h80 : 32'h0);
      r.e_jc     = 4 + v.slen;
      r.e_jaddr  = v.mtvec - (v.mtvec % 4);
      r.e_nwe    = 3;
    end else if (v.mret) begin
      r.e_ms    = (v.ms & 32'hFFFF_FF77) | 32'h80 | (mpie ? 32'h8 : 32'h0);
      r.e_jc    = 2 + v.slen;
      r.e_jaddr = v.mepc;
      r.e_nwe   = 1;
    end
    return r;
  endfunction

  task automatic apply(input vec_t v);
    int          jc, nj, nwe, hbad;
    logic [31:0] ja;
    cyc_start();
    m_mstatus = v.ms; m_mtvec = v.mtvec; m_mepc = v.mepc; m_mcause = 0;
    exc_cause_i = v.ecause; exc_pc_i = v.epc;
    int_cause_i = v.icause; int_pc_i = v.ipc;
    jc = -1; nj = 0; nwe = 0; hbad = 0; ja = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) cyc_start();
      exc_req_i    = v.exc && c == 0;
      mret_i       = v.mret && c == 0;
      int_req_i    = v.intr;
      exu_csr_we_i = c >= v.sat && c < v.sat + v.slen;
      sample();
      if (s_we) nwe++;
      if (jump_o) begin
        nj++;
        if (jc < 0) begin jc = c; ja = jump_addr_o; end
      end
      if (hold_o !== (c <= v.e_jc)) hbad++;
    end
    cyc_start();
    idle_inputs();
    chk({v.name, ".jump_cycle"}, jc, v.e_jc);
    chk({v.name, ".jump_count"}, nj, (v.e_jc < 0) ? 0 : 1);
    if (v.e_jc >= 0) chk({v.name, ".jump_addr"}, ja, v.e_jaddr);
    chk({v.name, ".csr_writes"}, nwe, v.e_nwe);
    chk({v.name, ".mepc"}, m_mepc, v.e_mepc);
    chk({v.name, ".mcause"}, m_mcause, v.e_mcause);
    chk({v.name, ".mstatus"}, m_mstatus, v.e_ms);
    chk({v.name, ".hold_bad_cycles"}, hbad, 0);
  endtask

  vec_t tbl[9];
  int   jq[$];
  vec_t rv;

  initial begin
    tbl[0] = mkv("exc_basic", 1, 0, 0, 11, 32'h100, 0, 0,
                 32'h8, 32'h103, 0, 0, 0,
                 32'h100, 11, 32'h80, 4, 32'h100, 3);
    tbl[1] = mkv("mret_basic", 0, 1, 0, 0, 0, 0, 0,
                 32'h80, 0, 32'h204, 0, 0,
                 32'h204, 0, 32'h88, 2, 32'h204, 1);
    tbl[2] = mkv("int_masked", 0, 0, 1, 0, 0, 32'h8000_0007, 32'h300,
                 32'h0, 32'h200, 32'h55, 0, 0,
                 32'h55, 0, 32'h0, -1, 0, 0);
    tbl[3] = mkv("int_taken", 0, 0, 1, 0, 0, 32'h8000_0007, 32'h300,
                 32'h8, 32'h200, 32'h55, 0, 0,
                 32'h300, 32'h8000_0007, 32'h80, 4, 32'h200, 3);
    tbl[4] = mkv("exc_int_same", 1, 0, 1, 2, 32'h400, 32'h8000_0007,
                 32'h300, 32'h8, 32'h1000, 0, 0, 0,
                 32'h400, 2, 32'h80, 4, 32'h1000, 3);
    tbl[5] = mkv("exc_stall", 1, 0, 0, 3, 32'h500, 0, 0,
                 32'h8, 32'h103, 0, 2, 2,
                 32'h500, 3, 32'h80, 6, 32'h100, 3);
    tbl[6] = mkv("mret_stall", 0, 1, 0, 0, 0, 0, 0,
                 32'h8, 0, 32'h600, 1, 1,
                 32'h600, 0, 32'h80, 3, 32'h600, 1);
    tbl[7] = mkv("exc_all_ones", 1, 0, 0, 11, 32'hFFFF_FFFC, 0, 0,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0,
                 32'hFFFF_FFFC, 11, 32'hFFFF_FFF7, 4, 32'hFFFF_FFFC, 3);
    tbl[8] = mkv("exc_over_mret", 1, 1, 0, 5, 32'h700, 0, 0,
                 32'h88, 32'h40, 32'h44, 0, 0,
                 32'h700, 5, 32'h80, 4, 32'h40, 3);

    rst = 1'b1;
    idle_inputs();
    s_we = 0; s_a = 0; s_d = 0;
    exc_cause_i = 0; exc_pc_i = 0; int_cause_i = 0; int_pc_i = 0;
    m_mstatus = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;

    // reset state, including a request presented during reset
    sample();
    exc_req_i = 1'b1;
    #1;
    chk("reset.csr_we", csr_we_o, 0);
    chk("reset.hold", hold_o, 0);
    chk("reset.jump", jump_o, 0);
    chk("reset.waddr", csr_waddr_o, 0);
    chk("reset.wdata", csr_wdata_o, 0);
    chk("reset.jaddr", jump_addr_o, 0);
    exc_req_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // back-to-back: new trap accepted in first IDLE after JUMP
    cyc_start();
    m_mstatus = 32'h8; m_mtvec = 32'h80; m_mepc = 0; m_mcause = 0;
    jq = {};
    for (int c = 0; c < 12; c++) begin
      if (c > 0) cyc_start();
      exc_req_i   = c == 0 || c == 5;
      exc_cause_i = (c < 5) ? 32'd3 : 32'd4;
      exc_pc_i    = (c < 5) ? 32'h10 : 32'h20;
      sample();
      if (jump_o) jq.push_back(c);
      if (c == 5) chk("b2b.hold_accept", hold_o, 1);
    end
    cyc_start();
    idle_inputs();
    chk("b2b.jump_count", jq.size(), 2);
    if (jq.size() == 2) begin
      chk("b2b.jump0", jq[0], 4);
      chk("b2b.jump1", jq[1], 9);
    end
    chk("b2b.mepc", m_mepc, 32'h20);
    chk("b2b.mcause", m_mcause, 4);
    chk("b2b.mstatus", m_mstatus, 0);

    // reset in W_MCAUSE aborts; mepc already written survives
    cyc_start();
    m_mstatus = 32'h8; m_mtvec = 32'h103; m_mepc = 0; m_mcause = 0;
    exc_req_i = 1; exc_cause_i = 11; exc_pc_i = 32'h100;
    sample();
    cyc_start();
    exc_req_i = 0;
    sample();
    cyc_start();
    sample();
    chk("rstmid.pre_we", csr_we_o, 1);
    chk("rstmid.pre_addr", csr_waddr_o, 32'h342);
    #2 rst = 1'b1;
    s_we = 1'b0;
    #1;
    chk("rstmid.csr_we", csr_we_o, 0);
    chk("rstmid.hold", hold_o, 0);
    chk("rstmid.waddr", csr_waddr_o, 0);
    chk("rstmid.wdata", csr_wdata_o, 0);
    chk("rstmid.jump", jump_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    begin
      int busy = 0;
      for (int c = 0; c < 8; c++) begin
        cyc_start();
        sample();
        busy += int'(jump_o) + int'(hold_o) + int'(csr_we_o);
      end
      chk("rstmid.idle_after", busy, 0);
    end
    chk("rstmid.mepc_kept", m_mepc, 32'h100);
    chk("rstmid.mcause", m_mcause, 0);

    // random traffic against the reference
    for (int n = 0; n < 40; n++) begin
      rv.name   = $sformatf("rand%0d", n);
      rv.exc    = 1'($urandom_range(1, 0));
      rv.mret   = 1'($urandom_range(1, 0));
      rv.intr   = 1'($urandom_range(1, 0));
      if (rv.mret && !rv.exc) rv.intr = 0;
      rv.ecause = $urandom_range(15, 0);
      rv.epc    = $urandom;
      rv.icause = 32'h8000_0000 | $urandom_range(15, 0);
      rv.ipc    = $urandom;
      rv.ms     = $urandom;
      rv.mtvec  = $urandom;
      rv.mepc   = $urandom;
      rv.sat    = 1;
      rv.slen   = 0;
      if (rv.exc || rv.mret || (rv.intr && rv.ms[3])) begin
        rv.slen = $urandom_range(3, 0);
        if (rv.exc || !rv.mret) rv.sat = $urandom_range(3, 1);
      end
      rv = predict(rv);
      apply(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap sequencer that owns the clint-side write port of the CSR register file (csr_reg).
- On a synchronous exception or an enabled interrupt, it holds the pipeline, writes mepc, mcause and mstatus in order, then redirects fetch to mtvec.
- On mret, it restores mstatus and redirects fetch to mepc.
- It sits between exu, the interrupt sources, csr_reg and the fetch/pipeline-control logic.

Parameters:
- MTVEC_ALIGN_MASK, 32'hFFFF_FFFC, mask applied to mtvec to form the trap target (direct mode only).
- INT_MIE_BIT, 3, mstatus bit position of MIE.
- INT_MPIE_BIT, 7, mstatus bit position of MPIE.

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- exc_req_i  in  1  synchronous exception request from exu (ecall/ebreak/illegal)
- exc_cause_i  in  32  mcause value for the exception
- exc_pc_i  in  32  PC of the excepting instruction
- int_req_i  in  1  level interrupt request
- int_cause_i  in  32  mcause value for the interrupt (bit31 set by source)
- int_pc_i  in  32  PC of the next un-executed instruction
- mret_i  in  1  mret executed in exu
- exu_csr_we_i  in  1  exu is writing a CSR this cycle
- mtvec_i  in  32  current mtvec from csr_reg
- mepc_i  in  32  current mepc from csr_reg
- mstatus_i  in  32  current mstatus from csr_reg
- csr_we_o  out  1  CSR write enable (clint port)
- csr_waddr_o  out  32  CSR write address (12-bit CSR number, zero-extended)
- csr_wdata_o  out  32  CSR write data
- hold_o  out  1  pipeline stall request
- jump_o  out  1  fetch redirect strobe
- jump_addr_o  out  32  redirect target

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE; csr_we_o, hold_o and jump_o = 0; csr_waddr_o, csr_wdata_o and jump_addr_o = 0; latched cause/epc = 0. Reset asserted mid-sequence aborts it immediately; partially written CSRs stay as written.
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, MRET_MSTATUS, JUMP.
- IDLE acceptance priority: exc_req_i > mret_i > (int_req_i & mstatus_i[INT_MIE_BIT]).
  - Exception accepted: latch epc=exc_pc_i and cause=exc_cause_i; go to W_MEPC.
  - mret accepted: go to MRET_MSTATUS.
  - Interrupt accepted: latch epc=int_pc_i and cause=int_cause_i; go to W_MEPC.
  - hold_o=1 combinationally in the accept cycle.
- W_MEPC: csr_we_o=1, waddr=12'h341, wdata=latched epc → W_MCAUSE.
- W_MCAUSE: csr_we_o=1, waddr=12'h342, wdata=latched cause → W_MSTATUS.
- W_MSTATUS: csr_we_o=1, waddr=12'h300, wdata=mstatus_i with MPIE←MIE and MIE←0 → JUMP with target = mtvec_i & MTVEC_ALIGN_MASK.
- MRET_MSTATUS: csr_we_o=1, waddr=12'h300, wdata=mstatus_i with MIE←MPIE and MPIE←1 → JUMP with target = mepc_i.
- JUMP: jump_o=1 for exactly one cycle, jump_addr_o=target, hold_o=1 → IDLE.
- hold_o=1 in every non-IDLE state.
- Latency: trap request to jump_o = 4 cycles; mret to jump_o = 2 cycles, assuming no exu conflict.
- Write conflict: if exu_csr_we_i=1 in any write state, csr_we_o=0 and the state is held. Data is re-evaluated and retried in the next cycle, because csr_reg gives exu priority.
- Inputs are sampled only in IDLE. exc_req_i/mret_i pulses while busy are ignored (the pipeline is held). A level int_req_i remains pending and is re-evaluated in IDLE.
- Interrupt with MIE=0: not taken; hold_o=0.
- Simultaneous exc_req_i and int_req_i: the exception is served and the interrupt stays pending. After trap entry MIE=0, so the interrupt is not taken until software re-enables it or mret.
- The first IDLE cycle after JUMP may accept a new request.

Decomposition:
- Shared package trap_pkg holds:
  - the state enum;
  - CSR address constants 12'h300/305/341/342, shared with existing defines;
  - MIE/MPIE bit positions;
  - the mstatus entry/exit update functions.
- No sub-module; single FSM plus latch registers.

Test Plan:
- Reset, mtvec=32'h0000_0103, mstatus=32'h8; exc_req_i with cause=11, pc=32'h100 →
  - writes mepc=32'h100, mcause=11, mstatus=32'h80 on cycles 1-3;
  - jump_o on cycle 4 with addr=32'h100;
  - hold_o high cycles 0-4.
- mstatus=32'h80, mepc=32'h204; mret_i pulse → mstatus write 32'h88 on cycle 1; jump_o on cycle 2 to 32'h204.
- int_req_i=1, cause=32'h8000_0007, mstatus=0 → no CSR writes and hold_o=0. Then set mstatus=32'h8 → trap entry with mcause=32'h8000_0007 and mepc=int_pc_i.
- exc_req_i and int_req_i in the same cycle with MIE=1 → exception cause written. After entry MIE=0, so int_req_i is not re-taken while still high.
- exu_csr_we_i=1 during W_MCAUSE for 2 cycles → csr_we_o=0 for those cycles, state holds, and jump_o is delayed by 2 cycles to cycle 6.
- rst asserted in W_MCAUSE → outputs go to 0 asynchronously. After release: state IDLE, no jump_o, and mepc keeps the value written before reset.
